geo_pixel_writer: RTL

Downstream stage of the geometry line generator. Consumes its per-pixel coordinate stream, clips each pixel to the active window, and converts it to a linear 8-bpp frame-buffer byte address. Results are buffered and issued as single-word writes to the memory arbiter. Backpressure to the generator is provided through a registered `draw_busy`, which freezes the generator on the same pixel until the writer can take it.

---
 rtl/geo_pkg.sv | 25 ++
 rtl/geo_sync_fifo.sv | 58 +++++
 rtl/geo_pixel_writer.sv | 161 ++++++++++++++++
 3 files changed

// File: rtl/geo_pkg.sv
// rtl/geo_pkg.sv - shared widths, write-entry type and clip helper for the geometry pixel path
package geo_pkg;

    localparam int COORD_W    = 12;
    localparam int COLOR_W    = 8;
    localparam int PROD_W     = 24;
    localparam int ADDR_W_MAX = 32;

    typedef struct packed {
        logic [ADDR_W_MAX-1:0] addr;
        logic [COLOR_W-1:0]    color;
    } pix_wr_t;

    // Negative coordinates are rejected first, so the unsigned compare only sees in-range values.
    function automatic logic clip_reject(
        input logic signed [COORD_W-1:0] x,
        input logic signed [COORD_W-1:0] y,
        input logic        [COORD_W-1:0] w,
        input logic        [COORD_W-1:0] h
    );
        return x[COORD_W-1] || y[COORD_W-1] ||
               ($unsigned(x) >= w) || ($unsigned(y) >= h);
    endfunction

endpackage

// File: rtl/geo_sync_fifo.sv
// rtl/geo_sync_fifo.sv - single-clock FIFO with occupancy count, power-of-two depth
module geo_sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_data,
    input  logic                     pop,
    output logic [WIDTH-1:0]         pop_data,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     empty,
    output logic                     full
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             push_ok;
    logic             pop_ok;

    always_comb begin
        pop_ok   = pop && (count_q != '0);
        push_ok  = push && ((count_q != CNT_W'(DEPTH)) || pop_ok);
        wr_ptr_d = push_ok ? wr_ptr_q + 1'b1 : wr_ptr_q;
        rd_ptr_d = pop_ok  ? rd_ptr_q + 1'b1 : rd_ptr_q;
        count_d  = count_q + CNT_W'(push_ok) - CNT_W'(pop_ok);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem_q[wr_ptr_q] <= push_data;
        end
    end

    assign pop_data = mem_q[rd_ptr_q];
    assign count    = count_q;
    assign empty    = (count_q == '0);
    assign full     = (count_q == CNT_W'(DEPTH));

endmodule

// File: rtl/geo_pixel_writer.sv
// rtl/geo_pixel_writer.sv - clips generator pixels, forms frame-buffer addresses, queues and issues byte writes
module geo_pixel_writer
    import geo_pkg::*;
#(
    parameter int FIFO_DEPTH = 8,
    parameter int ADDR_W     = 20
) (
    input  logic                      clk,
    input  logic                      reset_n,
    input  logic                      enable,
    input  logic                      pixel_data_rdy,
    input  logic signed [COORD_W-1:0] X_coord,
    input  logic signed [COORD_W-1:0] Y_coord,
    input  logic [COLOR_W-1:0]        color,
    input  logic [COORD_W-1:0]        clip_w,
    input  logic [COORD_W-1:0]        clip_h,
    input  logic [ADDR_W-1:0]         base_addr,
    input  logic [COORD_W-1:0]        stride,
    output logic                      draw_busy,
    output logic                      wr_ena,
    output logic [ADDR_W-1:0]         wr_addr,
    output logic [COLOR_W-1:0]        wr_data,
    input  logic                      wr_ack,
    output logic [15:0]               clipped_cnt,
    output logic                      idle
);

    localparam int CNT_W   = $clog2(FIFO_DEPTH) + 1;
    localparam int OCC_W   = CNT_W + 1;
    localparam int ENTRY_W = ADDR_W + COLOR_W;
    localparam int SUM_W   = (ADDR_W > PROD_W) ? ADDR_W : PROD_W;

    logic                accept;
    logic                reject;
    logic                s1_valid_q, s1_valid_d;
    logic [PROD_W-1:0]   s1_prod_q, s1_prod_d;
    logic [COORD_W-1:0]  s1_x_q, s1_x_d;
    logic [COLOR_W-1:0]  s1_color_q, s1_color_d;
    logic                s2_valid_q, s2_valid_d;
    logic [ADDR_W-1:0]   s2_addr_q, s2_addr_d;
    logic [COLOR_W-1:0]  s2_color_q, s2_color_d;
    logic [SUM_W-1:0]    addr_sum;
    logic                wr_ena_q, wr_ena_d;
    logic [ADDR_W-1:0]   wr_addr_q, wr_addr_d;
    logic [COLOR_W-1:0]  wr_data_q, wr_data_d;
    logic                draw_busy_q, draw_busy_d;
    logic [15:0]         clipped_cnt_q, clipped_cnt_d;
    logic                fifo_push;
    logic                fifo_pop;
    logic [ENTRY_W-1:0]  fifo_head;
    logic [CNT_W-1:0]    fifo_count;
    logic                fifo_empty;
    logic                fifo_full;
    logic [OCC_W-1:0]    count_next;
    logic [OCC_W-1:0]    occ_next;

    always_comb begin
        accept        = pixel_data_rdy && !draw_busy_q;
        reject        = clip_reject(X_coord, Y_coord, clip_w, clip_h);
        s1_valid_d    = accept && !reject;
        s1_prod_d     = s1_prod_q;
        s1_x_d        = s1_x_q;
        s1_color_d    = s1_color_q;
        clipped_cnt_d = clipped_cnt_q;
        if (s1_valid_d) begin
            s1_prod_d  = {{(PROD_W-COORD_W){1'b0}}, Y_coord} * {{(PROD_W-COORD_W){1'b0}}, stride};
            s1_x_d     = X_coord;
            s1_color_d = color;
        end
        if (accept && reject && (clipped_cnt_q != 16'hFFFF)) begin
            clipped_cnt_d = clipped_cnt_q + 16'd1;
        end
    end

    // Address sum is formed wide enough for the product and wraps to the bus width.
    always_comb begin
        addr_sum   = SUM_W'(base_addr) + SUM_W'(s1_prod_q) + SUM_W'(s1_x_q);
        s2_valid_d = s1_valid_q;
        s2_addr_d  = s2_addr_q;
        s2_color_d = s2_color_q;
        if (s1_valid_q) begin
            s2_addr_d  = addr_sum[ADDR_W-1:0];
            s2_color_d = s1_color_q;
        end
    end

    always_comb begin
        fifo_pop  = !fifo_empty && (!wr_ena_q || wr_ack);
        fifo_push = s2_valid_q && (!fifo_full || fifo_pop);
        wr_ena_d  = wr_ena_q;
        wr_addr_d = wr_addr_q;
        wr_data_d = wr_data_q;
        if (fifo_pop) begin
            wr_ena_d  = 1'b1;
            wr_addr_d = fifo_head[ENTRY_W-1:COLOR_W];
            wr_data_d = fifo_head[COLOR_W-1:0];
        end else if (wr_ack) begin
            wr_ena_d  = 1'b0;
        end
    end

    // Pipeline slots are counted as occupied so the FIFO can never be overrun.
    always_comb begin
        count_next  = OCC_W'(fifo_count) + OCC_W'(fifo_push) - OCC_W'(fifo_pop);
        occ_next    = count_next + OCC_W'(s1_valid_d) + OCC_W'(s2_valid_d);
        draw_busy_d = (occ_next >= OCC_W'(FIFO_DEPTH)) || !enable;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            s1_valid_q    <= 1'b0;
            s1_prod_q     <= '0;
            s1_x_q        <= '0;
            s1_color_q    <= '0;
            s2_valid_q    <= 1'b0;
            s2_addr_q     <= '0;
            s2_color_q    <= '0;
            wr_ena_q      <= 1'b0;
            wr_addr_q     <= '0;
            wr_data_q     <= '0;
            draw_busy_q   <= 1'b0;
            clipped_cnt_q <= '0;
        end else begin
            s1_valid_q    <= s1_valid_d;
            s1_prod_q     <= s1_prod_d;
            s1_x_q        <= s1_x_d;
            s1_color_q    <= s1_color_d;
            s2_valid_q    <= s2_valid_d;
            s2_addr_q     <= s2_addr_d;
            s2_color_q    <= s2_color_d;
            wr_ena_q      <= wr_ena_d;
            wr_addr_q     <= wr_addr_d;
            wr_data_q     <= wr_data_d;
            draw_busy_q   <= draw_busy_d;
            clipped_cnt_q <= clipped_cnt_d;
        end
    end

    geo_sync_fifo #(
        .WIDTH (ENTRY_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .reset_n   (reset_n),
        .push      (fifo_push),
        .push_data ({s2_addr_q, s2_color_q}),
        .pop       (fifo_pop),
        .pop_data  (fifo_head),
        .count     (fifo_count),
        .empty     (fifo_empty),
        .full      (fifo_full)
    );

    assign draw_busy   = draw_busy_q;
    assign wr_ena      = wr_ena_q;
    assign wr_addr     = wr_addr_q;
    assign wr_data     = wr_data_q;
    assign clipped_cnt = clipped_cnt_q;
    assign idle        = fifo_empty && !s1_valid_q && !s2_valid_q && !wr_ena_q;

endmodule
